// File: rtl/button_event_pkg.sv
// button_event_pkg: shared state encoding and time-to-cycle conversion for the button event unit
package button_event_pkg;

  typedef enum logic [1:0] {IDLE, PAUSE, REPEAT, HOLD} btn_state_t;

  function automatic int ns_to_cycles(input int ns, input int period_ns);
    return ns / period_ns;
  endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one button's synchroniser, debouncer and press/repeat/long-press FSM
module button_channel
  import button_event_pkg::*;
#(
  parameter int FILTER_CYC = 10,
  parameter int PAUSE_CYC  = 50,
  parameter int REPEAT_CYC = 20,
  parameter int LONG_CYC   = 100
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int TW = $clog2((PAUSE_CYC > REPEAT_CYC ? PAUSE_CYC : REPEAT_CYC) + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [FW-1:0] FILTER_M = FW'(FILTER_CYC);
  localparam logic [TW-1:0] PAUSE_M  = TW'(PAUSE_CYC);
  localparam logic [TW-1:0] REPEAT_M = TW'(REPEAT_CYC);
  localparam logic [HW-1:0] LONG_M   = HW'(LONG_CYC);

  logic [1:0]    sync_q, sync_d;
  logic [FW-1:0] deb_q, deb_d, deb_inc;
  logic          level_q, level_d;
  btn_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          press_q, press_d, release_q, release_d, long_q, long_d;
  logic          rise, fall, expire, counting, hold_sat;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q    <= '0;
      deb_q     <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      level_q   <= level_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Debounce: any cycle where the synchronised input agrees with the level restarts the count
  always_comb begin
    sync_d  = {sync_q[0], button_i};
    deb_inc = deb_q + 1'b1;
    deb_d   = (sync_q[1] != level_q && deb_inc != FILTER_M) ? deb_inc : '0;
    level_d = (sync_q[1] != level_q && deb_inc == FILTER_M) ? sync_q[1] : level_q;
    rise    = level_d & ~level_q;
    fall    = ~level_d & level_q;
  end

  // HOLD with repeat enabled behaves as the first cycle of a repeat period
  always_comb begin
    timer_inc = timer_q + 1'b1;
    expire    = (state_q == PAUSE) ? timer_inc == PAUSE_M : timer_inc == REPEAT_M;
    counting  = state_q == PAUSE || ((state_q == REPEAT || state_q == HOLD) && repeat_en_i);
    state_d   = fall ? IDLE :
                rise ? PAUSE :
                (state_q == PAUSE) ? (expire ? (repeat_en_i ? REPEAT : HOLD) : PAUSE) :
                (state_q == REPEAT || state_q == HOLD) ? (repeat_en_i ? REPEAT : HOLD) :
                state_q;
  end

  // Release wins over a coincident repeat or long-press expiry
  always_comb begin
    hold_inc  = hold_q + 1'b1;
    hold_sat  = hold_q == LONG_M;
    timer_d   = (!fall && !rise && counting && !expire) ? timer_inc : '0;
    hold_d    = (fall || rise || state_q == IDLE) ? '0 : hold_sat ? hold_q : hold_inc;
    press_d   = rise || (!fall && counting && expire && (state_q != PAUSE || repeat_en_i));
    long_d    = !fall && !rise && state_q != IDLE && !hold_sat && hold_inc == LONG_M;
    release_d = fall;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: NUMBER_BUTTONS independent debounced buttons with press, autorepeat, release and long-press events
module button_event_unit
  import button_event_pkg::*;
#(
  parameter int NUMBER_BUTTONS      = 4,
  parameter int CLOCK_PERIOD_NS     = 20,
  parameter int FILTER_PERIOD_NS    = 1_000_000,
  parameter int PAUSE_INTERVAL_NS   = 400_000_000,
  parameter int REPEATS_INTERVAL_NS = 150_000_000,
  parameter int LONG_PRESS_NS       = 1_000_000_000
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUMBER_BUTTONS-1:0] buttons_i,
  input  logic [NUMBER_BUTTONS-1:0] repeat_en_i,
  output logic [NUMBER_BUTTONS-1:0] level_o,
  output logic [NUMBER_BUTTONS-1:0] press_o,
  output logic [NUMBER_BUTTONS-1:0] release_o,
  output logic [NUMBER_BUTTONS-1:0] long_o
);

  localparam int FILTER_CYC = ns_to_cycles(FILTER_PERIOD_NS, CLOCK_PERIOD_NS);
  localparam int PAUSE_CYC  = ns_to_cycles(PAUSE_INTERVAL_NS, CLOCK_PERIOD_NS);
  localparam int REPEAT_CYC = ns_to_cycles(REPEATS_INTERVAL_NS, CLOCK_PERIOD_NS);
  localparam int LONG_CYC   = ns_to_cycles(LONG_PRESS_NS, CLOCK_PERIOD_NS);

  if (NUMBER_BUTTONS < 1 || FILTER_CYC < 1 || PAUSE_CYC < 1 || REPEAT_CYC < 1 || LONG_CYC < 1) begin : g_param_err
    $error("button_event_unit: NUMBER_BUTTONS and every derived cycle count must be >= 1");
  end

  for (genvar i = 0; i < NUMBER_BUTTONS; i++) begin : g_ch
    button_channel #(
      .FILTER_CYC(FILTER_CYC),
      .PAUSE_CYC (PAUSE_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .LONG_CYC  (LONG_CYC)
    ) u_ch (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .button_i   (buttons_i[i]),
      .repeat_en_i(repeat_en_i[i]),
      .level_o    (level_o[i]),
      .press_o    (press_o[i]),
      .release_o  (release_o[i]),
      .long_o     (long_o[i])
    );
  end

endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit: directed stimulus with an event scoreboard drained by a free-running monitor
module tb_button_event_unit;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
  } ev_t;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [N-1:0] buttons_i, repeat_en_i, level_o, press_o, release_o, long_o;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  t0, p0, a0, r0;

  button_event_unit #(
    .NUMBER_BUTTONS     (N),
    .CLOCK_PERIOD_NS    (20),
    .FILTER_PERIOD_NS   (200),
    .PAUSE_INTERVAL_NS  (1000),
    .REPEATS_INTERVAL_NS(400),
    .LONG_PRESS_NS      (2000)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .buttons_i  (buttons_i),
    .repeat_en_i(repeat_en_i),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .long_o     (long_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] l);
    ev_t e;
    e.cyc = c;
    e.pr  = p;
    e.rl  = r;
    e.lg  = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i === 1'b0 && (press_o | release_o | long_o) != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event at cycle %0d: press=%b release=%b long=%b, expected no event",
                 cyc, press_o, release_o, long_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.pr !== press_o || mon_e.rl !== release_o || mon_e.lg !== long_o) begin
          n_fail++;
          $display("FAIL event: got cycle %0d press=%b release=%b long=%b, expected cycle %0d press=%b release=%b long=%b",
                   cyc, press_o, release_o, long_o, mon_e.cyc, mon_e.pr, mon_e.rl, mon_e.lg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_i     = 1'b1;
    buttons_i   = '0;
    repeat_en_i = '0;
    wait_until(3);
    check("reset_outputs", {level_o, press_o, release_o, long_o}, 0);
    reset_i = 1'b0;
    wait_until(8);

    // Bounce on ch0: 5-cycle pulses never satisfy the 10-cycle filter
    for (int k = 0; k < 40; k++) begin
      buttons_i[0] = ~buttons_i[0];
      wait_until(cyc + 5);
      check("bounce_level", level_o[0], 0);
    end
    buttons_i[0] = 1'b0;
    wait_until(cyc + 20);

    // ch1 held 200 cycles with autorepeat
    repeat_en_i[1] = 1'b1;
    t0 = cyc;
    p0 = t0 + 12;
    for (int c = 0; c <= 200; c++) begin
      logic p, r, l;
      p = (c == 0) || (c >= 50 && c < 200 && (c - 50) % 20 == 0);
      l = (c == 100);
      r = (c == 200);
      if (p || r || l) push(p0 + c, p ? 4'b0010 : 4'b0000, r ? 4'b0010 : 4'b0000, l ? 4'b0010 : 4'b0000);
    end
    buttons_i[1] = 1'b1;
    wait_until(p0 - 1);
    check("latency_before_edge", level_o[1], 0);
    wait_until(p0);
    check("latency_at_edge", level_o[1], 1);
    wait_until(t0 + 200);
    buttons_i[1] = 1'b0;
    wait_until(t0 + 230);
    check("ch1_level_released", level_o[1], 0);
    repeat_en_i[1] = 1'b0;

    // ch2 held without repeat, repeat enabled later
    t0 = cyc;
    p0 = t0 + 12;
    push(p0,       4'b0100, 4'b0000, 4'b0000);
    push(p0 + 100, 4'b0000, 4'b0000, 4'b0100);
    push(p0 + 170, 4'b0100, 4'b0000, 4'b0000);
    push(p0 + 190, 4'b0100, 4'b0000, 4'b0000);
    push(p0 + 192, 4'b0000, 4'b0100, 4'b0000);
    buttons_i[2] = 1'b1;
    wait_until(p0 + 150);
    repeat_en_i[2] = 1'b1;
    wait_until(p0 + 180);
    buttons_i[2] = 1'b0;
    wait_until(p0 + 220);
    repeat_en_i[2] = 1'b0;

    // ch3 release lands on a repeat expiry
    repeat_en_i[3] = 1'b1;
    t0 = cyc;
    p0 = t0 + 12;
    push(p0,      4'b1000, 4'b0000, 4'b0000);
    push(p0 + 50, 4'b1000, 4'b0000, 4'b0000);
    push(p0 + 70, 4'b0000, 4'b1000, 4'b0000);
    buttons_i[3] = 1'b1;
    wait_until(t0 + 70);
    buttons_i[3] = 1'b0;
    wait_until(p0 + 110);
    repeat_en_i[3] = 1'b0;

    // All channels together
    t0 = cyc;
    p0 = t0 + 12;
    push(p0,      4'b1111, 4'b0000, 4'b0000);
    push(p0 + 20, 4'b0000, 4'b1111, 4'b0000);
    buttons_i = 4'b1111;
    wait_until(p0);
    check("all_levels_high", level_o, 4'b1111);
    wait_until(t0 + 20);
    buttons_i = 4'b0000;
    wait_until(t0 + 50);

    // Reset in the middle of a ch0 hold
    t0 = cyc;
    p0 = t0 + 12;
    push(p0, 4'b0001, 4'b0000, 4'b0000);
    buttons_i[0] = 1'b1;
    wait_until(p0 + 30);
    check("hold_level_before_reset", level_o[0], 1);
    reset_i = 1'b1;
    a0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      wait_until(a0 + k);
      check("reset_quiet", {level_o, press_o, release_o, long_o}, 0);
    end
    reset_i = 1'b0;
    r0 = cyc;
    push(r0 + 12, 4'b0001, 4'b0000, 4'b0000);
    wait_until(r0 + 20);
    buttons_i[0] = 1'b0;
    push(r0 + 32, 4'b0000, 4'b0001, 4'b0000);
    wait_until(r0 + 60);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_unit.md
BUTTON_EVENT_UNIT -- requirements
Module: button_event_unit

Interface
REQ-001 SHALL have parameter NUMBER_BUTTONS, default 4: channel count, >= 1.
REQ-002 SHALL have parameter CLOCK_PERIOD_NS, default 20: clk_i period.
REQ-003 SHALL have parameter FILTER_PERIOD_NS, default 1_000_000: debounce stability time.
REQ-004 SHALL have parameter PAUSE_INTERVAL_NS, default 400_000_000: press-to-first-repeat delay.
REQ-005 SHALL have parameter REPEATS_INTERVAL_NS, default 150_000_000: repeat period.
REQ-006 SHALL have parameter LONG_PRESS_NS, default 1_000_000_000: long-press threshold.
REQ-007 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port buttons_i, input, NUMBER_BUTTONS: raw asynchronous buttons, 1 = pressed.
REQ-010 SHALL have port repeat_en_i, input, NUMBER_BUTTONS: per-channel autorepeat enable.
REQ-011 SHALL have port level_o, output, NUMBER_BUTTONS: debounced level.
REQ-012 SHALL have port press_o, output, NUMBER_BUTTONS: 1-cycle pulse on press and on each autorepeat.
REQ-013 SHALL have port release_o, output, NUMBER_BUTTONS: 1-cycle pulse on release.
REQ-014 SHALL have port long_o, output, NUMBER_BUTTONS: 1-cycle pulse once per hold at long-press threshold.

Function
REQ-015 SHALL derive X_CYC = X_NS / CLOCK_PERIOD_NS (integer divide) for FILTER, PAUSE, REPEAT and LONG; each SHALL be >= 1, else elaboration error.
REQ-016 SHALL pass each buttons_i bit through a 2-flop synchroniser.
REQ-017 SHALL toggle level_o[i] only after the synchronised input differs from level_o[i] for FILTER_CYC consecutive cycles; any cycle of agreement clears the debounce counter.
REQ-018 SHALL make latency from a clean input edge to the level_o edge exactly 2 + FILTER_CYC cycles.
REQ-019 SHALL run one FSM per channel with states IDLE, PAUSE, REPEAT and HOLD.
REQ-020 SHALL, on a level_o rise, pulse press_o in the same cycle, clear the hold counter and go IDLE->PAUSE.
REQ-021 SHALL, in PAUSE after PAUSE_CYC cycles: if repeat_en_i=1, pulse press_o and go REPEAT; else go HOLD.
REQ-022 SHALL, in REPEAT, pulse press_o every REPEAT_CYC cycles; on repeat_en_i=0, go HOLD with no pulse.
REQ-023 SHALL, in HOLD, go REPEAT when repeat_en_i=1; the first pulse SHALL come REPEAT_CYC cycles after entry.
REQ-024 SHALL pulse long_o once when the hold counter reaches LONG_CYC after the press pulse; the counter SHALL saturate, with no further long_o until the next press.
REQ-025 SHALL, on a level_o fall in any state, pulse release_o in the same cycle, go IDLE and clear counters.
REQ-026 SHALL give release priority over a coincident repeat or long expiry: no press_o or long_o in that cycle.
REQ-027 SHALL keep channels independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-028 SHALL size counter widths by $clog2(max cycle constant + 1); counters SHALL never wrap.

Reset
REQ-029 SHALL, while reset_i=1, drive level_o, press_o, release_o and long_o to 0, clear synchronisers and counters, and put every FSM in IDLE.
REQ-030 SHALL, after reset mid-press, treat a still-held button as a new press: press_o pulses 2 + FILTER_CYC cycles after reset release, and release_o SHALL NOT pulse for the aborted press.

Structure
REQ-031 SHALL place btn_state_t (IDLE/PAUSE/REPEAT/HOLD) and an ns_to_cycles function in package button_event_pkg.
REQ-032 SHALL implement one sub-module, button_channel (synchroniser, debounce, FSM, counters), instantiated NUMBER_BUTTONS times in a generate loop.

Verification (CLOCK 20, FILTER 200, PAUSE 1000, REPEAT 400, LONG 2000 -> 10/50/20/100 cycles)
REQ-033 SHALL cover: button 0 pulse-trains of 5 cycles high/5 low for 200 cycles -> level_o and press_o stay 0.
REQ-034 SHALL cover: clean press on ch1, held 200 cycles, repeat_en=1 -> press_o at cycle t0+12, then +50, then every +20; long_o once at t0+112.
REQ-035 SHALL cover: ch2 held with repeat_en=0 -> single press_o, long_o at +100, no repeats; repeat_en raised at +150 -> next press_o at +170.
REQ-036 SHALL cover: release arranged so the level_o fall coincides with a repeat expiry -> release_o=1, press_o=0 that cycle, FSM IDLE.
REQ-037 SHALL cover: all 4 channels pressed in the same cycle -> press_o=4'b1111 in a single cycle.
REQ-038 SHALL cover: reset_i pulsed mid-hold -> outputs 0 during reset, no release_o, press_o 12 cycles after reset release.
